// File: rtl/rob_thread_arbiter.sv
// rob_thread_arbiter
//    Picks which of two hardware threads dispatches an instruction pair into
//    the ROB each cycle. It also tracks per-thread recovery after a committed
//    mispredict and retirement of a halt.
//
//    Build option: define ROUND_ROBIN_EN to alternate grants when both threads
//    are eligible. Without it, thread 1 has fixed priority.
//
// Ports
//    clock, reset                     system clock, synchronous active-high reset
//    t1_inst_valid, t2_inst_valid     fetch-queue valids (bit0 older, bit1 younger)
//    t1_is_full, t2_is_full           ROB partition cannot take a pair
//    commit1_*, commit2_*             ROB commit slot status (slot 1 is older)
//    is_thread1                       thread of the dispatched pair
//    inst1_load_in, inst2_load_in     ROB slot loads
//    t1_grant, t2_grant               fetch-queue pop for the granted thread
//    t1_flush, t2_flush               registered one-cycle squash pulse
//    t1_halted, t2_halted             thread has retired a halt
//
// Per-thread FSM
//    state     | meaning
//    ST_RUN    | may dispatch when not full and older slot valid
//    ST_FLUSH  | recovering from a mispredict; counter counts down to 0
//    ST_HALTED | halt retired; sticky until reset

module rob_thread_arbiter #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] t1_inst_valid,
   input  logic [1:0] t2_inst_valid,
   input  logic       t1_is_full,
   input  logic       t2_is_full,
   input  logic       commit1_valid,
   input  logic       commit1_is_thread1,
   input  logic       commit1_mispredict_out,
   input  logic       commit1_is_halt_out,
   input  logic       commit2_valid,
   input  logic       commit2_is_thread1,
   input  logic       commit2_mispredict_out,
   input  logic       commit2_is_halt_out,
   output logic       is_thread1,
   output logic       inst1_load_in,
   output logic       inst2_load_in,
   output logic       t1_grant,
   output logic       t2_grant,
   output logic       t1_flush,
   output logic       t2_flush,
   output logic       t1_halted,
   output logic       t2_halted
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_HALTED = 2'd2
   } thr_state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   // Index 0 = thread 1, index 1 = thread 2.
   thr_state_t state_q [2];
   logic [3:0] cnt_q   [2];
   logic [1:0] flush_q;
   logic       is_thread1_q;

   logic [1:0] full_v;
   logic [1:0] valid_old;
   logic [1:0] valid_young;
   logic [1:0] c1_hit;
   logic [1:0] c2_hit;
   logic [1:0] c1_older_event;
   logic [1:0] halt_ev;
   logic [1:0] mis_ev;
   logic [1:0] eligible;
   logic [1:0] grant;

   assign full_v      = {t2_is_full, t1_is_full};
   assign valid_old   = {t2_inst_valid[0], t1_inst_valid[0]};
   assign valid_young = {t2_inst_valid[1], t1_inst_valid[1]};

   assign c1_hit = {commit1_valid & ~commit1_is_thread1, commit1_valid & commit1_is_thread1};
   assign c2_hit = {commit2_valid & ~commit2_is_thread1, commit2_valid & commit2_is_thread1};

   // An older slot-1 event for the same thread suppresses a slot-2 mispredict.
   assign c1_older_event = c1_hit & {2{commit1_mispredict_out | commit1_is_halt_out}};

   assign halt_ev = (c1_hit & {2{commit1_is_halt_out}})
                  | (c2_hit & {2{commit2_is_halt_out}});

   assign mis_ev  = (c1_hit & {2{commit1_mispredict_out}})
                  | (c2_hit & {2{commit2_mispredict_out}} & ~c1_older_event);

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         eligible[i] = (state_q[i] == ST_RUN) && !full_v[i] && valid_old[i];
      end
   end

`ifdef ROUND_ROBIN_EN
   // 1 = thread 1 was granted last. Reset to thread 2 so thread 1 wins the first tie.
   logic last_grant_t1_q;

   always_comb begin
      if (eligible == 2'b11) begin
         grant = last_grant_t1_q ? 2'b10 : 2'b01;
      end else begin
         grant = eligible;
      end
   end
`else
   always_comb begin
      if (eligible[0]) begin
         grant = 2'b01;
      end else begin
         grant = eligible & 2'b10;
      end
   end
`endif

   assign t1_grant      = grant[0];
   assign t2_grant      = grant[1];
   assign inst1_load_in = |grant;
   assign inst2_load_in = |(grant & valid_young);
   assign is_thread1    = (|grant) ? grant[0] : is_thread1_q;

   assign t1_flush  = flush_q[0];
   assign t2_flush  = flush_q[1];
   assign t1_halted = (state_q[0] == ST_HALTED);
   assign t2_halted = (state_q[1] == ST_HALTED);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= ST_RUN;
            cnt_q[i]   <= 4'd0;
         end
         flush_q      <= 2'b00;
         is_thread1_q <= 1'b1;
`ifdef ROUND_ROBIN_EN
         last_grant_t1_q <= 1'b0;
`endif
      end else begin
         if (|grant) begin
            is_thread1_q <= grant[0];
`ifdef ROUND_ROBIN_EN
            last_grant_t1_q <= grant[0];
`endif
         end
         for (int i = 0; i < 2; i++) begin
            flush_q[i] <= 1'b0;
            case (state_q[i])
               ST_RUN, ST_FLUSH: begin
                  if (halt_ev[i]) begin
                     state_q[i] <= ST_HALTED;
                     cnt_q[i]   <= 4'd0;
                  end else if (mis_ev[i]) begin
                     // Also reloads when already flushing.
                     state_q[i] <= ST_FLUSH;
                     cnt_q[i]   <= FLUSH_LOAD;
                     flush_q[i] <= 1'b1;
                  end else if (state_q[i] == ST_FLUSH) begin
                     if (cnt_q[i] <= 4'd1) begin
                        state_q[i] <= ST_RUN;
                        cnt_q[i]   <= 4'd0;
                     end else begin
                        cnt_q[i] <= cnt_q[i] - 4'd1;
                     end
                  end
               end
               default: begin
                  state_q[i] <= ST_HALTED;
                  cnt_q[i]   <= 4'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rob_thread_arbiter.sv
// Directed bench for rob_thread_arbiter (FLUSH_CYCLES = 2).
// Expected output vectors are queued as each step is driven and popped when
// the outputs are sampled on the falling edge.
// Vector order: {is_thread1, inst1_load, inst2_load, t1_grant, t2_grant,
//                t1_flush, t2_flush, t1_halted, t2_halted}

module tb_rob_thread_arbiter;

   logic       clock;
   logic       reset;
   logic [1:0] t1_inst_valid;
   logic [1:0] t2_inst_valid;
   logic       t1_is_full;
   logic       t2_is_full;
   logic       commit1_valid;
   logic       commit1_is_thread1;
   logic       commit1_mispredict_out;
   logic       commit1_is_halt_out;
   logic       commit2_valid;
   logic       commit2_is_thread1;
   logic       commit2_mispredict_out;
   logic       commit2_is_halt_out;
   logic       is_thread1;
   logic       inst1_load_in;
   logic       inst2_load_in;
   logic       t1_grant;
   logic       t2_grant;
   logic       t1_flush;
   logic       t2_flush;
   logic       t1_halted;
   logic       t2_halted;

   rob_thread_arbiter #(.FLUSH_CYCLES(2)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .t1_inst_valid          (t1_inst_valid),
      .t2_inst_valid          (t2_inst_valid),
      .t1_is_full             (t1_is_full),
      .t2_is_full             (t2_is_full),
      .commit1_valid          (commit1_valid),
      .commit1_is_thread1     (commit1_is_thread1),
      .commit1_mispredict_out (commit1_mispredict_out),
      .commit1_is_halt_out    (commit1_is_halt_out),
      .commit2_valid          (commit2_valid),
      .commit2_is_thread1     (commit2_is_thread1),
      .commit2_mispredict_out (commit2_mispredict_out),
      .commit2_is_halt_out    (commit2_is_halt_out),
      .is_thread1             (is_thread1),
      .inst1_load_in          (inst1_load_in),
      .inst2_load_in          (inst2_load_in),
      .t1_grant               (t1_grant),
      .t2_grant               (t2_grant),
      .t1_flush               (t1_flush),
      .t2_flush               (t2_flush),
      .t1_halted              (t1_halted),
      .t2_halted              (t2_halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string      tag;
      logic [8:0] exp_v;
   } sb_t;

   sb_t sb_q [$];
   int  n_assert = 0;
   int  n_fail   = 0;

   task automatic set_in(input logic [1:0] v1, input logic [1:0] v2,
                         input logic f1, input logic f2);
      t1_inst_valid = v1;
      t2_inst_valid = v2;
      t1_is_full    = f1;
      t2_is_full    = f2;
   endtask

   task automatic set_c1(input logic v, input logic is_t1, input logic mis, input logic halt);
      commit1_valid          = v;
      commit1_is_thread1     = is_t1;
      commit1_mispredict_out = mis;
      commit1_is_halt_out    = halt;
   endtask

   task automatic set_c2(input logic v, input logic is_t1, input logic mis, input logic halt);
      commit2_valid          = v;
      commit2_is_thread1     = is_t1;
      commit2_mispredict_out = mis;
      commit2_is_halt_out    = halt;
   endtask

   task automatic clr_commits();
      set_c1(1'b0, 1'b0, 1'b0, 1'b0);
      set_c2(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_out();
      sb_t        e;
      logic [8:0] obs;
      obs = {is_thread1, inst1_load_in, inst2_load_in, t1_grant, t2_grant,
             t1_flush, t2_flush, t1_halted, t2_halted};
      n_assert++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %b expected an entry", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp_v);
         end
      end
   endtask

   // Queue the expectation for the current cycle, check it mid-cycle, then
   // advance to just after the next rising edge.
   task automatic cyc(input string tag, input logic [8:0] exp_v);
      sb_q.push_back('{tag, exp_v});
      @(negedge clock);
      check_out();
      @(posedge clock);
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      set_in(2'b00, 2'b00, 1'b0, 1'b0);
      clr_commits();
      tick();
      reset = 1'b0;
      cyc("reset_state", 9'b1_00_00_00_00);

      // Thread 1 full, thread 2 single valid.
      set_in(2'b11, 2'b01, 1'b1, 1'b0);
      cyc("t1_full_t2_single", 9'b0_10_01_00_00);

      set_in(2'b00, 2'b00, 1'b0, 1'b0);
      cyc("idle_holds_thread", 9'b0_00_00_00_00);

      // Both threads eligible with full pairs.
      set_in(2'b11, 2'b11, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
`ifdef ROUND_ROBIN_EN
         cyc("both_eligible_rr", (i % 2 == 0) ? 9'b1_11_10_00_00 : 9'b0_11_01_00_00);
`else
         cyc("both_eligible_fixed", 9'b1_11_10_00_00);
`endif
      end

      // Thread-1 mispredict on slot 1; thread 1 still dispatches that cycle.
      set_in(2'b01, 2'b01, 1'b0, 1'b0);
      set_c1(1'b1, 1'b1, 1'b1, 1'b0);
      cyc("t1_mis_cycle_n", 9'b1_10_10_00_00);
      clr_commits();
      cyc("t1_flush_n1", 9'b0_10_01_10_00);
      cyc("t1_flush_n2", 9'b0_10_01_00_00);
      cyc("t1_eligible_n3", 9'b1_10_10_00_00);

      // Thread-2 mispredict on slot 2, then again while flushing.
      set_in(2'b00, 2'b01, 1'b0, 1'b0);
      set_c2(1'b1, 1'b0, 1'b1, 1'b0);
      cyc("t2_mis_slot2", 9'b0_10_01_00_00);
      clr_commits();
      set_c1(1'b1, 1'b0, 1'b1, 1'b0);
      cyc("t2_flush_remis", 9'b0_00_00_01_00);
      clr_commits();
      cyc("t2_flush_repulse", 9'b0_00_00_01_00);
      cyc("t2_flush_count", 9'b0_00_00_00_00);
      cyc("t2_run_again", 9'b0_10_01_00_00);

      // Independent mispredicts for both threads in one cycle.
      set_in(2'b00, 2'b00, 1'b0, 1'b0);
      set_c1(1'b1, 1'b1, 1'b1, 1'b0);
      set_c2(1'b1, 1'b0, 1'b1, 1'b0);
      cyc("dual_mis", 9'b0_00_00_00_00);
      clr_commits();
      cyc("dual_flush", 9'b0_00_00_11_00);
      cyc("dual_flush_count", 9'b0_00_00_00_00);
      set_in(2'b01, 2'b01, 1'b0, 1'b0);
      cyc("dual_run_again", 9'b1_10_10_00_00);

      // Both slots mispredict for thread 1: one pulse only.
      set_in(2'b00, 2'b00, 1'b0, 1'b0);
      set_c1(1'b1, 1'b1, 1'b1, 1'b0);
      set_c2(1'b1, 1'b1, 1'b1, 1'b0);
      cyc("double_mis_same_thread", 9'b1_00_00_00_00);
      clr_commits();
      cyc("single_pulse", 9'b1_00_00_10_00);
      cyc("single_pulse_end", 9'b1_00_00_00_00);
      cyc("single_pulse_idle", 9'b1_00_00_00_00);

      // Reset while flushing with counter at 1.
      set_c1(1'b1, 1'b1, 1'b1, 1'b0);
      cyc("mis_before_reset", 9'b1_00_00_00_00);
      clr_commits();
      cyc("flush_before_reset", 9'b1_00_00_10_00);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_in(2'b01, 2'b01, 1'b0, 1'b0);
      cyc("after_reset_cnt1", 9'b1_10_10_00_00);

      // Reset while flushing with counter at 2.
      set_in(2'b00, 2'b00, 1'b0, 1'b0);
      set_c1(1'b1, 1'b1, 1'b1, 1'b0);
      cyc("mis_before_reset2", 9'b1_00_00_00_00);
      clr_commits();
      reset = 1'b1;
      cyc("flush_during_reset", 9'b1_00_00_10_00);
      reset = 1'b0;
      set_in(2'b01, 2'b00, 1'b0, 1'b0);
      cyc("after_reset_cnt2", 9'b1_10_10_00_00);

      // Halt on slot 1 with a same-cycle slot-2 mispredict for thread 1.
      set_c1(1'b1, 1'b1, 1'b0, 1'b1);
      set_c2(1'b1, 1'b1, 1'b1, 1'b0);
      cyc("halt_cycle", 9'b1_10_10_00_00);
      clr_commits();
      cyc("halted_no_flush", 9'b1_00_00_00_10);
      set_in(2'b01, 2'b01, 1'b0, 1'b0);
      cyc("halted_t2_only", 9'b0_10_01_00_10);
      set_in(2'b11, 2'b00, 1'b0, 1'b0);
      set_c1(1'b1, 1'b1, 1'b1, 1'b0);
      cyc("halted_ignores_mis", 9'b0_00_00_00_10);
      clr_commits();
      set_in(2'b01, 2'b00, 1'b0, 1'b0);
      cyc("halted_sticky", 9'b0_00_00_00_10);

      // Reset releases a halted thread.
      set_in(2'b00, 2'b00, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_in(2'b01, 2'b00, 1'b0, 1'b0);
      cyc("reset_from_halted", 9'b1_10_10_00_00);

      if (sb_q.size() != 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rob_thread_arbiter.md
ROB_THREAD_ARBITER -- requirements
Module: rob_thread_arbiter

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: recovery cycles per thread after a committed mispredict; legal range 1..15.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 t1_inst_valid  input  2  thread-1 fetch-queue valid; bit0 = older slot, bit1 = younger slot.
REQ-005 t2_inst_valid  input  2  thread-2 fetch-queue valid; same bit order.
REQ-006 t1_is_full, t2_is_full  input  1 each  ROB partition cannot accept a pair.
REQ-007 commit1_valid, commit1_is_thread1, commit1_mispredict_out, commit1_is_halt_out  input  1 each  ROB commit slot 1 status.
REQ-008 commit2_valid, commit2_is_thread1, commit2_mispredict_out, commit2_is_halt_out  input  1 each  ROB commit slot 2 status.
REQ-009 is_thread1  output  1  thread of the pair dispatched this cycle; drives ROB is_thread1.
REQ-010 inst1_load_in, inst2_load_in  output  1 each  ROB slot loads.
REQ-011 t1_grant, t2_grant  output  1 each  fetch queue pops the granted slots this cycle.
REQ-012 t1_flush, t2_flush  output  1 each  registered one-cycle squash pulse to that thread's front end.
REQ-013 t1_halted, t2_halted  output  1 each  thread retired a halt.

Function
REQ-014 Per-thread FSM with states RUN, FLUSH, HALTED; eligible = RUN and not full and inst_valid[0].
REQ-015 Dispatch outputs are combinational from current state and inputs; at most one thread is granted per cycle.
REQ-016 inst1_load_in = granted; inst2_load_in = granted and granted thread's inst_valid[1]; inst_valid[1] without inst_valid[0] is never loaded.
REQ-017 No eligible thread: all loads/grants 0, is_thread1 holds its last value.
REQ-018 Thread mispredict detected when a valid commit slot tagged for that thread has mispredict set; the thread's next state is FLUSH, its flush pulse asserts the following cycle, and its counter loads FLUSH_CYCLES.
REQ-019 FLUSH decrements once per cycle and returns to RUN when the counter reaches 0; the thread is not granted while in FLUSH.
REQ-020 Mispredict while in FLUSH reloads the counter and re-pulses flush.
REQ-021 Halt committed for a thread moves it to HALTED (sticky until reset); halted_out = 1 from the next cycle; halt wins over a same-cycle mispredict on either slot.
REQ-022 Commit slot 2 mispredict is ignored if commit slot 1 of the same thread is a mispredict or halt in the same cycle (older event wins, single flush pulse).
REQ-023 Events for thread 1 and thread 2 in the same cycle are handled independently.
REQ-024 A thread granted in the same cycle its mispredict commits still dispatches; the flush pulse covers those entries.

Reset
REQ-025 Reset: both FSMs RUN, counters 0, last_grant = thread 2 (thread 1 wins first tie), is_thread1 = 1, all flush/halted outputs 0.
REQ-026 Reset mid-FLUSH or in HALTED returns to RUN on the next edge; no flush pulse is emitted after reset.

Configuration
REQ-027 ROUND_ROBIN_EN defined: when both threads are eligible, grant the thread not granted last; last_grant updates only on an actual grant.
REQ-028 ROUND_ROBIN_EN undefined: fixed priority, thread 1 wins whenever eligible; last_grant is unused.

Verification
REQ-029 Both threads valid 2'b11 for 4 cycles, not full, ROUND_ROBIN_EN -> is_thread1 = 1,0,1,0; both loads 1 each cycle.
REQ-030 t1_is_full = 1, t2_inst_valid = 2'b01 -> t2_grant = 1, is_thread1 = 0, inst1_load_in = 1, inst2_load_in = 0.
REQ-031 Commit1 thread-1 mispredict at cycle N, FLUSH_CYCLES = 2 -> t1_flush = 1 at N+1 only; thread 1 not granted at N+1 and N+2; eligible again from N+3.
REQ-032 Same cycle: commit1 thread-1 halt and commit2 thread-1 mispredict -> t1_halted = 1 next cycle, t1_flush stays 0, thread 1 never granted again.
REQ-033 Reset asserted in FLUSH with counter = 1 -> next cycle RUN, t1_flush = 0, thread 1 granted first.
REQ-034 ROUND_ROBIN_EN undefined, both threads eligible for 3 cycles -> is_thread1 = 1 on all 3 cycles; t2_grant = 0.
